alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Registered RV32I integer ALU for the single-cycle datapath's execute stage.
- Computes arithmetic, logic, shift and compare results from two operands, a 4-bit operation select and funct3.
- Produces a result and a zero/branch-taken flag.
- One-cycle latency with a valid strobe.

Parameters:
- WIDTH, 32, operand/result width; shift amount uses in2[$clog2(WIDTH)-1:0] (5 bits at default).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/select valid this cycle.
- in1  input  WIDTH  operand A (rs1).
- in2  input  WIDTH  operand B (rs2 or immediate).
- alu_sel  input  4  operation select.
- func3  input  3  branch condition select, used only when alu_sel=0010.
- out_valid  output  1  result/zero valid.
- result  output  WIDTH  registered result.
- zero  output  1  registered zero / branch-taken flag.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, result=0, zero=0; held until rst_n deasserts.
- Latency: in_valid=1 at edge N → result/zero/out_valid updated at edge N.
  - Visible after edge N, one cycle latency.
  - out_valid = registered in_valid.
  - result/zero hold their last value when in_valid=0.
- No backpressure; a new operation is accepted every cycle.
- alu_sel decode:
  - 0000 ADD: in1+in2, wraps mod 2^WIDTH.
  - 0001 SUB: in1-in2, wraps.
  - 0010 BRANCH: result = in1-in2; zero = branch condition (below).
  - 0011 PASS: result = in2 (LUI).
  - 0100 OR.
  - 0101 AND.
  - 0111 XOR.
  - 1000 SRL: logical right shift by in2[4:0].
  - 1001 SLL: left shift by in2[4:0].
  - 1010 SRA: arithmetic right shift by in2[4:0].
  - 1101 SLT: signed in1<in2 → 1 else 0, zero-extended.
  - 1111 SLTU: unsigned in1<in2 → 1 else 0.
  - All other codes: result=0.
- Shift amount uses only in2[4:0]; upper bits ignored.
- zero for all non-BRANCH codes = (result==0).
- BRANCH zero (1 = taken), by func3:
  - 000 BEQ: in1==in2.
  - 001 BNE: in1!=in2.
  - 100 BLT: signed in1<in2.
  - 101 BGE: signed in1>=in2.
  - 110 BLTU: unsigned in1<in2.
  - 111 BGEU: unsigned in1>=in2.
  - 010/011: zero=0.
- Signed compares must be correct across overflow: use true signed comparison, not the subtraction sign bit.
- func3 is ignored outside BRANCH.
- Reset mid-operation: pending result is discarded; out_valid=0 on the first cycle after release until a new in_valid.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds outputs carry(1), overflow(1), negative(1), registered alongside result with identical latency and reset to 0.
  - carry = carry-out of ADD, or NOT borrow for SUB/BRANCH.
  - overflow = signed overflow of ADD/SUB/BRANCH.
  - negative = result[WIDTH-1].
  - carry and overflow are 0 for other codes.
- Undefined: these ports and their logic do not exist; all other behaviour is unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-stream → out_valid=0, result=0, zero=0 immediately, without a clock edge.
- Arithmetic and logic, in1=10, in2=5, one cycle per op:
  - ADD=15, SUB=5, AND=0 (zero=1), OR=15, XOR=15.
  - SRL=0 (zero=1), SLL=320, SLT=0 (zero=1).
  - Each valid one cycle after in_valid.
- Unsigned compares: in1=0x0000000A, in2=0xF0000005:
  - SLTU → result=1, zero=0.
  - SLT → result=0, zero=1.
- Branches, alu_sel=0010:
  - in1=in2=10, func3=000 → zero=1.
  - in1=0x10A, in2=0xA, func3=001 → zero=1.
  - in1=5, in2=10, func3=100 → zero=1.
  - in1=0x0F000005, in2=0xA, func3=110 → zero=0.
  - func3=011 → zero=0.
- Shift and overflow edges:
  - in1=0x80000000, in2=0x21 → SRA=0xC0000000, SRL=0x40000000.
  - ADD 0x7FFFFFFF+1 → 0x80000000; with ALU_FLAGS_EN, overflow=1.
  - SLT 0x80000000 < 0x7FFFFFFF → 1.
- Throughput: back-to-back in_valid for 8 cycles with random ops → 8 consecutive out_valid results matching a reference model; in_valid=0 → result holds its last value.

Source files
------------

// File: rtl/alu_core.sv
// Registered RV32I execute-stage ALU: result, zero/branch-taken flag and valid strobe, one cycle latency.
// Optional status flags (carry, overflow, negative) are built when ALU_FLAGS_EN is defined.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_sel,
  input  logic [2:0]       func3,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_BR   = 4'b0010;
  localparam logic [3:0] SEL_PASS = 4'b0011;
  localparam logic [3:0] SEL_OR   = 4'b0100;
  localparam logic [3:0] SEL_AND  = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0111;
  localparam logic [3:0] SEL_SRL  = 4'b1000;
  localparam logic [3:0] SEL_SLL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
  localparam logic [3:0] SEL_SLT  = 4'b1101;
  localparam logic [3:0] SEL_SLTU = 4'b1111;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] diff;
  logic             eq, lt_s, lt_u;
  logic             br_taken;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             valid_q;

  assign shamt = in2[SHW-1:0];
  assign diff  = in1 - in2;
  assign eq    = (in1 == in2);
  // True signed compare so overflowing differences cannot flip the answer.
  assign lt_s  = ($signed(in1) < $signed(in2));
  assign lt_u  = (in1 < in2);

  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt_s;
      3'b101:  br_taken = !lt_s;
      3'b110:  br_taken = lt_u;
      3'b111:  br_taken = !lt_u;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    result_d = '0;
    case (alu_sel)
      SEL_ADD:  result_d = in1 + in2;
      SEL_SUB:  result_d = diff;
      SEL_BR:   result_d = diff;
      SEL_PASS: result_d = in2;
      SEL_OR:   result_d = in1 | in2;
      SEL_AND:  result_d = in1 & in2;
      SEL_XOR:  result_d = in1 ^ in2;
      SEL_SRL:  result_d = in1 >> shamt;
      SEL_SLL:  result_d = in1 << shamt;
      SEL_SRA:  result_d = $signed(in1) >>> shamt;
      SEL_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_s};
      SEL_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_u};
      default:  result_d = '0;
    endcase
    zero_d = (alu_sel == SEL_BR) ? br_taken : (result_d == '0);
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_w, sub_w;
  logic           carry_d, ovf_d;
  logic           carry_q, ovf_q, neg_q;

  assign add_w = {1'b0, in1} + {1'b0, in2};
  assign sub_w = {1'b0, in1} - {1'b0, in2};

  // For subtraction the carry is the inverted borrow, as in most ISAs' C flag.
  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (alu_sel)
      SEL_ADD: begin
        carry_d = add_w[WIDTH];
        ovf_d   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_w[WIDTH-1] != in1[WIDTH-1]);
      end
      SEL_SUB, SEL_BR: begin
        carry_d = !sub_w[WIDTH];
        ovf_d   = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_w[WIDTH-1] != in1[WIDTH-1]);
      end
      default: begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else if (in_valid) begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      neg_q   <= result_d[WIDTH-1];
    end
  end

  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign negative = neg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed spec vectors plus random back-to-back ops against a behavioural model.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [3:0]  alu_sel = '0;
  logic [2:0]  func3 = '0;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
`ifdef ALU_FLAGS_EN
  logic        carry, overflow, negative;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_r = '0;
  logic        exp_z = 1'b0;
  logic        exp_c = 1'b0;
  logic        exp_v = 1'b0;

  always #5 clk = ~clk;

  alu_core #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .alu_sel  (alu_sel),
    .func3    (func3),
    .out_valid(out_valid),
    .result   (result),
    .zero     (zero)
`ifdef ALU_FLAGS_EN
    ,
    .carry    (carry),
    .overflow (overflow),
    .negative (negative)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the RV32I definitions.
  function automatic void model(input logic [3:0] s, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic z,
                                output logic c, output logic v);
    int ia, ib;
    longint sa, sb, ss;
    longint unsigned ua, ub;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = a;  ub = b;
    r = '0; c = 1'b0; v = 1'b0;
    case (s)
      4'd0: begin
        r = a + b;
        c = ((ua + ub) >= 64'h1_0000_0000);
        ss = sa + sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd1, 4'd2: begin
        r = a - b;
        c = (ua >= ub);
        ss = sa - sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd3:  r = b;
      4'd4:  r = a | b;
      4'd5:  r = a & b;
      4'd7:  r = a ^ b;
      4'd8:  r = a >> b[4:0];
      4'd9:  r = a << b[4:0];
      4'd10: r = ia >>> b[4:0];
      4'd13: r = {31'b0, (ia < ib)};
      4'd15: r = {31'b0, (ua < ub)};
      default: r = '0;
    endcase
    z = (r == 0);
    if (s == 4'd2) begin
      case (f)
        3'd0: z = (a == b);
        3'd1: z = (a != b);
        3'd4: z = (ia < ib);
        3'd5: z = (ia >= ib);
        3'd6: z = (ua < ub);
        3'd7: z = (ua >= ub);
        default: z = 1'b0;
      endcase
    end
  endfunction

  task automatic check_outputs(input string tag, input logic vld);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, vld});
    chk({tag, ".result"}, result, exp_r);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_z});
`ifdef ALU_FLAGS_EN
    chk({tag, ".carry"}, {31'b0, carry}, {31'b0, exp_c});
    chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, exp_v});
    chk({tag, ".neg"}, {31'b0, negative}, {31'b0, exp_r[31]});
`endif
  endtask

  // Drive one op; r_exp/z_exp are the independently known answers.
  task automatic op(input string tag, input logic [3:0] s, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] r_exp, input logic z_exp);
    logic [31:0] mr;
    logic mz, mc, mv;
    @(negedge clk);
    in_valid = 1'b1; alu_sel = s; func3 = f; in1 = a; in2 = b;
    model(s, f, a, b, mr, mz, mc, mv);
    exp_r = r_exp; exp_z = z_exp; exp_c = mc; exp_v = mv;
    @(posedge clk); #1;
    check_outputs(tag, 1'b1);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; alu_sel = 4'($urandom); func3 = 3'($urandom);
    @(posedge clk); #1;
    check_outputs(tag, 1'b0);
  endtask

  initial begin
    logic [31:0] mr;
    logic mz, mc, mv;
    logic [3:0] rs;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    #1;
    exp_r = '0; exp_z = 1'b0; exp_c = 1'b0; exp_v = 1'b0;
    check_outputs("reset", 1'b0);
    @(negedge clk); rst_n = 1'b1;

    op("add",  4'b0000, 3'd0, 32'd10, 32'd5, 32'd15, 1'b0);
    op("sub",  4'b0001, 3'd0, 32'd10, 32'd5, 32'd5,  1'b0);
    op("and",  4'b0101, 3'd0, 32'd10, 32'd5, 32'd0,  1'b1);
    op("or",   4'b0100, 3'd0, 32'd10, 32'd5, 32'd15, 1'b0);
    op("xor",  4'b0111, 3'd0, 32'd10, 32'd5, 32'd15, 1'b0);
    op("srl",  4'b1000, 3'd0, 32'd10, 32'd5, 32'd0,  1'b1);
    op("sll",  4'b1001, 3'd0, 32'd10, 32'd5, 32'd320, 1'b0);
    op("slt",  4'b1101, 3'd0, 32'd10, 32'd5, 32'd0,  1'b1);
    op("pass", 4'b0011, 3'd5, 32'd10, 32'hABCD0000, 32'hABCD0000, 1'b0);
    op("undef", 4'b0110, 3'd0, 32'd10, 32'd5, 32'd0, 1'b1);

    op("sltu_u", 4'b1111, 3'd0, 32'h0000000A, 32'hF0000005, 32'd1, 1'b0);
    op("slt_u",  4'b1101, 3'd0, 32'h0000000A, 32'hF0000005, 32'd0, 1'b1);

    op("beq",  4'b0010, 3'b000, 32'd10, 32'd10, 32'd0, 1'b1);
    op("bne",  4'b0010, 3'b001, 32'h10A, 32'hA, 32'h100, 1'b1);
    op("blt",  4'b0010, 3'b100, 32'd5, 32'd10, 32'hFFFFFFFB, 1'b1);
    op("bltu", 4'b0010, 3'b110, 32'h0F000005, 32'hA, 32'h0EFFFFFB, 1'b0);
    op("b011", 4'b0010, 3'b011, 32'd5, 32'd10, 32'hFFFFFFFB, 1'b0);
    op("bge",  4'b0010, 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    op("bgeu", 4'b0010, 3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1);

    op("sra",  4'b1010, 3'd0, 32'h80000000, 32'h21, 32'hC0000000, 1'b0);
    op("srl1", 4'b1000, 3'd0, 32'h80000000, 32'h21, 32'h40000000, 1'b0);
    op("addov", 4'b0000, 3'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("addov.ovf_const", {31'b0, overflow}, 32'd1);
`endif
    op("sltov", 4'b1101, 3'd0, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0);
    op("addc",  4'b0000, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);

    idle("hold0");
    idle("hold1");

    for (int i = 0; i < 8; i++) begin
      rs = 4'($urandom);
      rf = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      model(rs, rf, ra, rb, mr, mz, mc, mv);
      op($sformatf("rnd%0d", i), rs, rf, ra, rb, mr, mz);
    end
    idle("rnd_hold");

    // Reset asserted while an op is in flight must clear outputs without a clock edge.
    op("pre_rst", 4'b0000, 3'd0, 32'd100, 32'd23, 32'd123, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; alu_sel = 4'b0000; in1 = 32'd7; in2 = 32'd8;
    #2 rst_n = 1'b0;
    #1;
    exp_r = '0; exp_z = 1'b0; exp_c = 1'b0; exp_v = 1'b0;
    check_outputs("async_rst", 1'b0);
    @(posedge clk); #1;
    check_outputs("rst_held", 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rst", 1'b0);
    op("after_rst", 4'b0001, 3'd0, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
